// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: access size codes, FSM state codes
// and the store-side byte-enable / write-data helpers.
package mem_pkg;

  // Access size encodings (2'b11 is treated as a word everywhere)
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  // Data-memory access FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Byte enables for an access of the given size at the given byte offset
  function automatic logic [3:0] gen_be(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      MEM_BYTE: gen_be = 4'b0001 << offset;
      MEM_HALF: gen_be = 4'b0011 << offset;
      default:  gen_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated so every byte lane carries the right value
  function automatic logic [31:0] gen_wdata(input logic [1:0] size, input logic [31:0] sd);
    case (size)
      MEM_BYTE: gen_wdata = {4{sd[7:0]}};
      MEM_HALF: gen_wdata = {2{sd[15:0]}};
      default:  gen_wdata = sd;
    endcase
  endfunction

  // Natural alignment check: bytes always, halves on even, words on 4-byte
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      MEM_BYTE: is_aligned = 1'b1;
      MEM_HALF: is_aligned = ~offset[0];
      default:  is_aligned = (offset == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Load data alignment: shifts the addressed bytes of a memory word down to
// bit 0 and sign- or zero-extends them according to the access size.
module load_align_ext
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = word_i >> {offset_i, 3'b000};

  // Extend the low byte/half of the shifted word
  always_comb begin
    data_o = shifted;
    case (size_i)
      MEM_BYTE: data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      MEM_HALF: data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      default:  data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores over a req/gnt/rvalid data-memory
// handshake, stalls the pipeline while an access is outstanding and hands
// extended load data to the MEM/WB register.
// Optional: define DMEM_TIMEOUT_EN to abort accesses stuck in REQ/WAIT for
// TIMEOUT_CYCLES cycles and report the abort on bus_err_o.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  rd_waddr_i,
  input  logic        rd_wena_i,
  input  logic        rd_sel_i,
  output logic [4:0]  rd_waddr_o,
  output logic        rd_wena_o,
  output logic        rd_sel_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] dmem_data_o,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        bus_err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  logic [1:0]  state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [1:0]  off_q, size_q;
  logic        uns_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        mem_op, aligned, start, is_idle, complete, abort;
  logic [31:0] ext_data;

  assign mem_op  = valid_i & (mem_rd_i | mem_wr_i);
  assign aligned = is_aligned(mem_size_i, alu_result_i[1:0]);
  assign is_idle = (state_q == ST_IDLE);
  assign start   = mem_op & aligned & is_idle;

  // Accesses that finish normally this cycle; these win over a timeout
  assign complete = ((state_q == ST_REQ) & dmem_gnt_i & we_q) |
                    ((state_q == ST_WAIT) & dmem_rvalid_i);

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            abort_q;
  logic            busy;

  assign busy  = (state_q == ST_REQ) | (state_q == ST_WAIT);
  assign abort = busy & (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) & ~complete;

  // Cycle counter: clears outside REQ/WAIT, counts while an access is pending
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (busy) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  // Remember that the DONE we are heading into is an abort
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      abort_q <= 1'b0;
    end else if (abort) begin
      abort_q <= 1'b1;
    end else if (state_q == ST_DONE) begin
      abort_q <= 1'b0;
    end
  end

  assign bus_err_o = ~rst_i & (state_q == ST_DONE) & abort_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign abort          = 1'b0;
  assign bus_err_o      = 1'b0;
`endif

  // Next-state and hold-register logic for the access FSM
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          hold_d = '0;
          if (dmem_gnt_i) state_d = mem_wr_i ? ST_DONE : ST_WAIT;
          else            state_d = ST_REQ;
        end
      end
      ST_REQ:  if (dmem_gnt_i) state_d = we_q ? ST_DONE : ST_WAIT;
      ST_WAIT: begin
        if (dmem_rvalid_i) begin
          hold_d  = dmem_rdata_i;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_DONE;
      hold_d  = '0;
    end
  end

  // FSM state and load hold register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Snapshot of the request so the bus stays stable while waiting for gnt
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (start) begin
      off_q   <= alu_result_i[1:0];
      size_q  <= mem_size_i;
      uns_q   <= mem_unsigned_i;
      we_q    <= mem_wr_i;
      addr_q  <= {alu_result_i[31:2], 2'b00};
      be_q    <= gen_be(mem_size_i, alu_result_i[1:0]);
      wdata_q <= gen_wdata(mem_size_i, store_data_i);
    end
  end

  load_align_ext u_load_align_ext (
    .word_i     (hold_q),
    .offset_i   (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ext_data)
  );

  assign dmem_req_o   = ~rst_i & (start | (state_q == ST_REQ));
  assign dmem_we_o    = is_idle ? mem_wr_i : we_q;
  assign dmem_addr_o  = is_idle ? {alu_result_i[31:2], 2'b00} : addr_q;
  assign dmem_be_o    = is_idle ? gen_be(mem_size_i, alu_result_i[1:0]) : be_q;
  assign dmem_wdata_o = is_idle ? gen_wdata(mem_size_i, store_data_i) : wdata_q;

  assign stall_o      = ~rst_i & (start | (state_q == ST_REQ) | (state_q == ST_WAIT));
  assign misaligned_o = ~rst_i & mem_op & ~aligned;
  assign dmem_data_o  = (state_q == ST_DONE) ? ext_data : '0;

  assign rd_waddr_o   = rd_waddr_i;
  assign rd_sel_o     = rd_sel_i;
  assign alu_result_o = alu_result_i;
  assign rd_wena_o    = rd_wena_i & valid_i & ~misaligned_o & ~bus_err_o;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage. A behavioural memory responder
// and arithmetic reference model live in this file.
module tb_mem_access_stage;

  localparam int unsigned TimeoutCycles = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, mem_rd_i, mem_wr_i, mem_unsigned_i;
  logic [1:0]  mem_size_i;
  logic [31:0] alu_result_i, store_data_i;
  logic [4:0]  rd_waddr_i;
  logic        rd_wena_i, rd_sel_i;
  logic [4:0]  rd_waddr_o;
  logic        rd_wena_o, rd_sel_o;
  logic [31:0] alu_result_o, dmem_data_o;
  logic        stall_o, misaligned_o, bus_err_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  mem_access_stage #(
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .valid_i        (valid_i),
    .mem_rd_i       (mem_rd_i),
    .mem_wr_i       (mem_wr_i),
    .mem_size_i     (mem_size_i),
    .mem_unsigned_i (mem_unsigned_i),
    .alu_result_i   (alu_result_i),
    .store_data_i   (store_data_i),
    .rd_waddr_i     (rd_waddr_i),
    .rd_wena_i      (rd_wena_i),
    .rd_sel_i       (rd_sel_i),
    .rd_waddr_o     (rd_waddr_o),
    .rd_wena_o      (rd_wena_o),
    .rd_sel_o       (rd_sel_o),
    .alu_result_o   (alu_result_o),
    .dmem_data_o    (dmem_data_o),
    .stall_o        (stall_o),
    .misaligned_o   (misaligned_o),
    .bus_err_o      (bus_err_o),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_be_o      (dmem_be_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_gnt_i     (dmem_gnt_i),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .dmem_rdata_i   (dmem_rdata_i)
  );

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic m_misaligned(input logic [1:0] sz, input logic [31:0] addr);
    return (addr % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] addr);
    int v;
    v = ((1 << nbytes(sz)) - 1) << (addr % 4);
    return 4'(v);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] sd);
    if (nbytes(sz) == 1) return (sd % 256) * 32'h0101_0101;
    if (nbytes(sz) == 2) return (sd % 65536) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [31:0] addr,
                                         input logic [1:0] sz, input logic uns);
    logic [31:0] v, mask;
    int bits;
    v = rdata >> (8 * (addr % 4));
    bits = 8 * nbytes(sz);
    if (bits == 32) return v;
    mask = (32'd1 << bits) - 1;
    v = v & mask;
    if (!uns && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- memory responder ----------------
  // Runs one access; gnt comes gd cycles after the request starts, rvalid rvd
  // cycles after gnt. Observations are returned for the caller to judge.
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] addr, input logic [31:0] sd,
                            input logic [31:0] rdata, input int gd, input int rvd,
                            output int stalls, output int reqs, output logic [31:0] o_addr,
                            output logic [3:0] o_be, output logic [31:0] o_wdata,
                            output logic o_we, output logic stable, output logic [31:0] o_data,
                            output logic o_wena, output logic o_done);
    int phase, k, w;
    phase = 0; k = 0; w = 0;
    stalls = 0; reqs = 0; stable = 1'b1; o_done = 1'b0;
    o_addr = '0; o_be = '0; o_wdata = '0; o_we = 1'b0; o_data = '0; o_wena = 1'b0;
    valid_i = 1'b1; mem_rd_i = rd; mem_wr_i = wr; mem_size_i = sz; mem_unsigned_i = uns;
    alu_result_i = addr; store_data_i = sd; rd_wena_i = rd; rd_sel_i = rd; rd_waddr_i = 5'd7;
    for (int c = 0; c < 100 && !o_done; c++) begin
      dmem_gnt_i    = (phase == 0) && (k == gd);
      dmem_rvalid_i = (phase == 1) && (w == rvd);
      dmem_rdata_i  = dmem_rvalid_i ? rdata : $urandom();
      @(negedge clk_i);
      if (stall_o) stalls++;
      if (phase == 2) begin
        o_data = dmem_data_o; o_wena = rd_wena_o; o_done = 1'b1;
      end else if (phase == 0) begin
        if (dmem_req_o) begin
          if (reqs == 0) begin
            o_addr = dmem_addr_o; o_be = dmem_be_o; o_wdata = dmem_wdata_o; o_we = dmem_we_o;
          end else if (o_addr !== dmem_addr_o || o_be !== dmem_be_o ||
                       o_wdata !== dmem_wdata_o || o_we !== dmem_we_o) begin
            stable = 1'b0;
          end
          reqs++;
        end
        if (dmem_req_o && dmem_gnt_i) begin
          phase = wr ? 2 : 1;
          w = 1;
        end
        k++;
      end else begin
        if (dmem_rvalid_i) phase = 2;
        else w++;
      end
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0; mem_rd_i = 1'b0; mem_wr_i = 1'b0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b1;
    valid_i = 1'b1; mem_rd_i = 1'b1; mem_size_i = 2'b10; alu_result_i = 32'h101;
    rd_wena_i = 1'b1;
    #1;
    n_checks++;
    if (misaligned_o !== 1'b0) begin
      n_errors++; $display("FAIL reset_misaligned: got %b expected 0", misaligned_o);
    end
    alu_result_i = 32'h100;
    #1;
    n_checks++;
    if (dmem_req_o !== 1'b0) begin
      n_errors++; $display("FAIL reset_req: got %b expected 0", dmem_req_o);
    end
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_errors++; $display("FAIL reset_stall: got %b expected 0", stall_o);
    end
    n_checks++;
    if (bus_err_o !== 1'b0 || dmem_data_o !== 32'h0) begin
      n_errors++; $display("FAIL reset_err_data: got %b/%h expected 0/0", bus_err_o, dmem_data_o);
    end
    valid_i = 1'b0; mem_rd_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_word_load();
    int st, rq; logic [31:0] a, wd, d; logic [3:0] be; logic we, stb, wena, dn;
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1,
               st, rq, a, be, wd, we, stb, d, wena, dn);
    n_checks++;
    if (!dn || st != 2) begin
      n_errors++; $display("FAIL word_load_stall: got %0d (done=%b) expected 2", st, dn);
    end
    n_checks++;
    if (d !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL word_load_data: got %h expected deadbeef", d);
    end
    n_checks++;
    if (wena !== 1'b1 || a !== 32'h100 || be !== 4'hF || we !== 1'b0) begin
      n_errors++;
      $display("FAIL word_load_bus: got wena=%b addr=%h be=%b we=%b expected 1/100/1111/0",
               wena, a, be, we);
    end
  endtask

  task automatic test_byte_load();
    int st, rq; logic [31:0] a, wd, d; logic [3:0] be; logic we, stb, wena, dn;
    for (int u = 0; u < 2; u++) begin
      run_access(1'b1, 1'b0, 2'b00, u[0], 32'h103, 32'h0, 32'h80FF_FF7F, 0, 1,
                 st, rq, a, be, wd, we, stb, d, wena, dn);
      n_checks++;
      if (be !== 4'b1000 || a !== 32'h100) begin
        n_errors++; $display("FAIL byte_load_be: got %b/%h expected 1000/100", be, a);
      end
      n_checks++;
      if (d !== (u ? 32'h0000_0080 : 32'hFFFF_FF80)) begin
        n_errors++; $display("FAIL byte_load_data uns=%0d: got %h", u, d);
      end
    end
  endtask

  task automatic test_half_store();
    int st, rq; logic [31:0] a, wd, d; logic [3:0] be; logic we, stb, wena, dn;
    run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234_ABCD, 32'h0, 3, 1,
               st, rq, a, be, wd, we, stb, d, wena, dn);
    n_checks++;
    if (!dn || rq != 4 || st != 4) begin
      n_errors++; $display("FAIL half_store_len: got req=%0d stall=%0d expected 4/4", rq, st);
    end
    n_checks++;
    if (a !== 32'h200 || be !== 4'b1100 || wd !== 32'hABCD_ABCD || we !== 1'b1) begin
      n_errors++;
      $display("FAIL half_store_bus: got %h/%b/%h/%b expected 200/1100/abcdabcd/1", a, be, wd, we);
    end
    n_checks++;
    if (stb !== 1'b1 || wena !== 1'b0) begin
      n_errors++; $display("FAIL half_store_stable: got stable=%b wena=%b expected 1/0", stb, wena);
    end
  endtask

  task automatic test_misaligned();
    logic [1:0]  szs[6]   = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11};
    logic [31:0] addrs[6] = '{32'h101, 32'h102, 32'h103, 32'h201, 32'h203, 32'h302};
    logic mis;
    for (int i = 0; i < 6; i++) begin
      valid_i = 1'b1; mem_rd_i = i[0]; mem_wr_i = ~i[0]; mem_size_i = szs[i];
      alu_result_i = addrs[i]; rd_wena_i = 1'b1; rd_waddr_i = 5'(i + 3);
      mis = m_misaligned(szs[i], addrs[i]);
      @(negedge clk_i);
      n_checks++;
      if (misaligned_o !== mis || dmem_req_o !== !mis || stall_o !== !mis ||
          rd_wena_o !== !mis) begin
        n_errors++;
        $display("FAIL misaligned %0d: got mis=%b req=%b stall=%b wena=%b expected mis=%b",
                 i, misaligned_o, dmem_req_o, stall_o, rd_wena_o, mis);
      end
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0; mem_rd_i = 1'b0; mem_wr_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_passthrough();
    logic v, w;
    for (int i = 0; i < 8; i++) begin
      v = 1'($urandom()); w = 1'($urandom());
      valid_i = v; mem_rd_i = ~v; mem_wr_i = 1'b0; mem_size_i = 2'($urandom());
      alu_result_i = $urandom(); rd_waddr_i = 5'($urandom()); rd_wena_i = w;
      rd_sel_i = 1'($urandom());
      @(negedge clk_i);
      n_checks++;
      if (alu_result_o !== alu_result_i || rd_waddr_o !== rd_waddr_i ||
          rd_sel_o !== rd_sel_i || rd_wena_o !== (v & w) || stall_o !== 1'b0 ||
          dmem_req_o !== 1'b0) begin
        n_errors++;
        $display("FAIL passthrough %0d: got alu=%h wa=%h sel=%b wena=%b stall=%b req=%b",
                 i, alu_result_o, rd_waddr_o, rd_sel_o, rd_wena_o, stall_o, dmem_req_o);
      end
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0; mem_rd_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    int st, rq; logic [31:0] a, wd, d; logic [3:0] be; logic we, stb, wena, dn;
    valid_i = 1'b1; mem_rd_i = 1'b1; mem_wr_i = 1'b0; mem_size_i = 2'b10;
    alu_result_i = 32'h300; rd_wena_i = 1'b1; dmem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    dmem_gnt_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    n_checks++;
    if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || dmem_data_o !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_mid: got req=%b stall=%b data=%h expected 0", dmem_req_o, stall_o,
               dmem_data_o);
    end
    valid_i = 1'b0; mem_rd_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
    @(negedge clk_i);
    n_checks++;
    if (stall_o !== 1'b0 || dmem_data_o !== 32'h0) begin
      n_errors++; $display("FAIL late_rvalid: got stall=%b data=%h expected 0", stall_o, dmem_data_o);
    end
    @(posedge clk_i); #1;
    dmem_rvalid_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (dmem_data_o !== 32'h0) begin
      n_errors++; $display("FAIL late_rvalid_done: got %h expected 0", dmem_data_o);
    end
    @(posedge clk_i); #1;
    run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h302, 32'h0, 32'h8765_4321, 1, 2,
               st, rq, a, be, wd, we, stb, d, wena, dn);
    n_checks++;
    if (!dn || st != 4 || d !== 32'h0000_8765 || wena !== 1'b1) begin
      n_errors++;
      $display("FAIL post_reset_load: got stall=%0d data=%h wena=%b expected 4/00008765/1",
               st, d, wena);
    end
  endtask

  task automatic test_random();
    int st, rq, gd, rvd, n; logic [31:0] a, wd, d, addr, sd, rdata; logic [3:0] be;
    logic we, stb, wena, dn, wr, uns; logic [1:0] sz;
    for (int i = 0; i < 30; i++) begin
      sz = 2'($urandom_range(0, 3)); n = nbytes(sz);
      addr = $urandom(); addr = addr - (addr % n);
      wr = 1'($urandom()); uns = 1'($urandom());
      sd = $urandom(); rdata = $urandom();
      gd = $urandom_range(0, 2); rvd = $urandom_range(1, 2);
      run_access(~wr, wr, sz, uns, addr, sd, rdata, gd, rvd,
                 st, rq, a, be, wd, we, stb, d, wena, dn);
      n_checks++;
      if (!dn || st != (wr ? gd + 1 : gd + 1 + rvd) || stb !== 1'b1) begin
        n_errors++;
        $display("FAIL rand_timing %0d: got stall=%0d stable=%b done=%b gd=%0d rvd=%0d wr=%b",
                 i, st, stb, dn, gd, rvd, wr);
      end
      n_checks++;
      if (a !== (addr & 32'hFFFF_FFFC) || be !== m_be(sz, addr) || we !== wr) begin
        n_errors++;
        $display("FAIL rand_bus %0d: got %h/%b/%b expected %h/%b/%b", i, a, be, we,
                 addr & 32'hFFFF_FFFC, m_be(sz, addr), wr);
      end
      n_checks++;
      if (wr ? (wd !== m_wdata(sz, sd) || wena !== 1'b0)
             : (d !== m_load(rdata, addr, sz, uns) || wena !== 1'b1)) begin
        n_errors++;
        $display("FAIL rand_data %0d: got wdata=%h data=%h wena=%b expected wdata=%h data=%h",
                 i, wd, d, wena, m_wdata(sz, sd), m_load(rdata, addr, sz, uns));
      end
    end
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout();
    int st; logic found, wena_err, stall_err; logic [31:0] data_err;
    st = 0; found = 1'b0; wena_err = 1'b1; stall_err = 1'b1; data_err = '1;
    valid_i = 1'b1; mem_rd_i = 1'b1; mem_size_i = 2'b10; alu_result_i = 32'h400;
    rd_wena_i = 1'b1; dmem_gnt_i = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk_i);
      if (bus_err_o) begin
        found = 1'b1; wena_err = rd_wena_o; stall_err = stall_o; data_err = dmem_data_o;
      end else if (stall_o) begin
        st++;
      end
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0; mem_rd_i = 1'b0;
    n_checks++;
    // One start cycle in IDLE plus TimeoutCycles cycles in REQ
    if (!found || st != 1 + TimeoutCycles) begin
      n_errors++; $display("FAIL timeout_len: got found=%b stall=%0d expected 1/%0d", found, st,
                           1 + TimeoutCycles);
    end
    n_checks++;
    if (wena_err !== 1'b0 || stall_err !== 1'b0 || data_err !== 32'h0) begin
      n_errors++; $display("FAIL timeout_done: got wena=%b stall=%b data=%h expected 0",
                           wena_err, stall_err, data_err);
    end
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1111_2222;
    @(negedge clk_i);
    n_checks++;
    if (bus_err_o !== 1'b0 || stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin
      n_errors++; $display("FAIL timeout_pulse: got err=%b stall=%b req=%b expected 0",
                           bus_err_o, stall_o, dmem_req_o);
    end
    @(posedge clk_i); #1;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (dmem_data_o !== 32'h0 || bus_err_o !== 1'b0) begin
      n_errors++; $display("FAIL timeout_late: got data=%h err=%b expected 0", dmem_data_o,
                           bus_err_o);
    end
    @(posedge clk_i); #1;
  endtask
`else
  task automatic test_timeout();
    int st, rq; logic [31:0] a, wd, d; logic [3:0] be; logic we, stb, wena, dn;
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h5A5A_0F0F, 12, 2,
               st, rq, a, be, wd, we, stb, d, wena, dn);
    n_checks++;
    if (!dn || st != 15 || d !== 32'h5A5A_0F0F || wena !== 1'b1 || bus_err_o !== 1'b0) begin
      n_errors++; $display("FAIL long_wait: got stall=%0d data=%h wena=%b expected 15/5a5a0f0f/1",
                           st, d, wena);
    end
  endtask
`endif

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; mem_rd_i = 1'b0; mem_wr_i = 1'b0; mem_size_i = 2'b00;
    mem_unsigned_i = 1'b0; alu_result_i = '0; store_data_i = '0; rd_waddr_i = '0;
    rd_wena_i = 1'b0; rd_sel_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    dmem_rdata_i = '0;
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_passthrough();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
